vga_timing_monitor: RTL and testbench
=====================================

// Module: vga_timing_monitor
// PURPOSE
//  Receive-side counterpart of the VGA timing generator. Samples hsync/vsync/vga_blank_n on the
//  pixel-enable strobe and recovers per-pixel x/y coordinates plus a data-enable. Measures line
//  length, active width, active height and lines per frame, and asserts locked once timing is
//  stable. Sits behind a capture/scaler path or a self-check of the local VGA output.
// PARAMETERS
//  LOG2_DISPLAY_WIDTH   10  width of horizontal counters/measurements
//  LOG2_DISPLAY_HEIGHT  10  width of vertical counters/measurements
//  LOCK_FRAMES          2   consecutive identical frame measurements required for lock (1..15)
// PORTS
//  clk          in   1    system clock
//  rst          in   1    asynchronous reset, active-high
//  pix_en       in   1    pixel strobe: inputs are sampled only in clk cycles where pix_en=1
//  hsync        in   1    horizontal sync, active-low, synchronous to clk
//  vsync        in   1    vertical sync, active-low, synchronous to clk
//  vga_blank_n  in   1    1 = active pixel
//  de           out  1    registered data-enable for the sampled pixel
//  x            out  LOG2_DISPLAY_WIDTH   active-pixel column (valid when de=1)
//  y            out  LOG2_DISPLAY_HEIGHT  active-line row (valid when de=1)
//  frame_start  out  1    one-clk pulse on a detected vsync falling edge
//  h_total      out  LOG2_DISPLAY_WIDTH   measured pixels per line (hsync fall to hsync fall)
//  h_active     out  LOG2_DISPLAY_WIDTH   measured active pixels in the last active line
//  v_active     out  LOG2_DISPLAY_HEIGHT  measured active lines in the last frame
//  v_total      out  LOG2_DISPLAY_HEIGHT  measured hsync falls per frame
//  locked       out  1    timing stable for LOCK_FRAMES frames
// BEHAVIOUR
//  - Reset: every output and internal register is 0. All state updates only on pix_en=1, except
//    frame_start, which is 0 on every clk without a detected edge.
//  - Edge detection: hs_d/vs_d/bl_d hold the previous sample (reset to 1/1/0).
//    hs_fall = hs_d & ~hsync; vs_fall = vs_d & ~vsync; bl_fall = bl_d & ~vga_blank_n.
//  - hcnt: on hs_fall, h_total <= hcnt+1 and hcnt <= 0. Otherwise hcnt increments, saturating at
//    all-ones. Saturation is a sync-loss: locked <= 0 and the match counter clears.
//  - Active pixels: when vga_blank_n=1, de <= 1, x <= xcnt, y <= ycnt, and xcnt increments.
//    When vga_blank_n=0, de <= 0 and x/y hold. xcnt clears on hs_fall.
//    de/x/y are registered, so they appear 1 clk after the sampling pix_en cycle.
//  - On bl_fall: h_active <= xcnt and ycnt increments (saturating).
//  - vcnt_next = vcnt + hs_fall (saturating).
//  - On vs_fall: v_total <= vcnt_next; v_active <= ycnt (plus 1 if bl_fall in the same sample);
//    vcnt <= 0; ycnt <= 0; frame_start = 1.
//  - Per-line check: if hs_fall and hcnt+1 != h_total, set frame_bad.
//    frame_bad clears on vs_fall after the comparison below.
//  - Lock, evaluated on each vs_fall:
//    - The new {h_total, h_active, v_active, v_total} is compared with the previous frame's snapshot.
//    - Equal and frame_bad=0: match count increments, saturating at LOCK_FRAMES.
//    - Otherwise: match count <= 0 and locked <= 0.
//    - locked <= (match count == LOCK_FRAMES). The snapshot is always updated.
//    - The first vs_fall after reset never matches (snapshot invalid).
//  - Simultaneous hs_fall and vs_fall: both are processed; that hsync counts toward the closing frame.
//  - Reset mid-frame: immediate return to reset state. Lock needs LOCK_FRAMES+1 full frames.
// TESTING
//  1. 640x480 stimulus (800 px/line, 525 lines, 640x480 active), pix_en every 2nd clk ->
//     h_total=800, h_active=640, v_active=480, v_total=525; locked=1 at the 3rd vs_fall.
//  2. First active pixel of a frame -> de=1, x=0, y=0 one clk later. Last pixel -> x=639, y=479.
//  3. Locked, then one line of 801 px -> frame_bad set; locked=0 at the next vs_fall;
//     relocks after 2 further clean frames.
//  4. hsync held high for 1024 samples -> locked=0 on saturation, h_total unchanged until the next hs_fall.
//  5. Assert rst mid-line while locked -> all outputs 0 asynchronously; relock after 3 frames.
//  6. hs_fall and vs_fall in the same sample -> v_total counts that line; frame_start pulses exactly 1 clk.

Source files
------------

// File: rtl/vga_timing_monitor.sv
// Purpose: receive-side VGA timing monitor; recovers de/x/y and measures line/frame geometry, flags lock.
// Latency: de/x/y, measurements and locked update 1 clk after the sampling pix_en cycle.
// Backpressure: none; a passive observer that consumes every pix_en sample.
module vga_timing_monitor #(
  parameter int LOG2_DISPLAY_WIDTH  = 10,
  parameter int LOG2_DISPLAY_HEIGHT = 10,
  // Consecutive identical frames needed before locked asserts; legal range 1..15.
  parameter int LOCK_FRAMES         = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pix_en,
  input  logic                           hsync,
  input  logic                           vsync,
  input  logic                           vga_blank_n,
  output logic                           de,
  output logic [LOG2_DISPLAY_WIDTH-1:0]  x,
  output logic [LOG2_DISPLAY_HEIGHT-1:0] y,
  output logic                           frame_start,
  output logic [LOG2_DISPLAY_WIDTH-1:0]  h_total,
  output logic [LOG2_DISPLAY_WIDTH-1:0]  h_active,
  output logic [LOG2_DISPLAY_HEIGHT-1:0] v_active,
  output logic [LOG2_DISPLAY_HEIGHT-1:0] v_total,
  output logic                           locked
);

  localparam int HW = LOG2_DISPLAY_WIDTH;
  localparam int VW = LOG2_DISPLAY_HEIGHT;
  // Snapshot layout: {h_total, h_active, v_active, v_total}
  localparam int SW = 2 * HW + 2 * VW;

  localparam logic [HW-1:0] H_ONE    = {{(HW-1){1'b0}}, 1'b1};
  localparam logic [VW-1:0] V_ONE    = {{(VW-1){1'b0}}, 1'b1};
  localparam logic [3:0]    LOCK_MAX = 4'(LOCK_FRAMES);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic          hs_q, vs_q, bl_q;

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [HW-1:0] xcnt_q, xcnt_d;
  logic [VW-1:0] ycnt_q, ycnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;

  logic [HW-1:0] h_total_q, h_total_d;
  logic [HW-1:0] h_active_q, h_active_d;
  logic [VW-1:0] v_active_q, v_active_d;
  logic [VW-1:0] v_total_q, v_total_d;

  logic          de_q, de_d;
  logic [HW-1:0] x_q, x_d;
  logic [VW-1:0] y_q, y_d;
  logic          fs_q;

  logic [3:0]    match_q, match_d;
  logic          locked_q, locked_d;
  logic          frame_bad_q, frame_bad_d;
  logic [SW-1:0] snap_q, snap_d;
  logic          snap_vld_q, snap_vld_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic          hs_fall, vs_fall, bl_fall;
  logic [HW-1:0] hcnt_inc;
  logic          sync_loss;
  logic          line_bad;
  logic [VW-1:0] ycnt_step;
  logic [VW-1:0] vcnt_next;
  logic [SW-1:0] frame_meas;
  logic          frame_match;

  // Edges are only meaningful on sample cycles, so pix_en is folded in here.
  always_comb begin
    hs_fall = pix_en & hs_q & ~hsync;
    vs_fall = pix_en & vs_q & ~vsync;
    bl_fall = pix_en & bl_q & ~vga_blank_n;
  end

  // Horizontal counter: measure on hsync fall, otherwise count and detect runaway lines.
  always_comb begin
    hcnt_inc  = hcnt_q + H_ONE;
    hcnt_d    = hcnt_q;
    h_total_d = h_total_q;
    sync_loss = 1'b0;
    if (hs_fall) begin
      h_total_d = hcnt_inc;
      hcnt_d    = '0;
    end else if (pix_en) begin
      // A counter pinned at all-ones means hsync has gone missing.
      if (&hcnt_q) begin
        sync_loss = 1'b1;
      end else begin
        hcnt_d = hcnt_inc;
      end
    end
    // Compared against the previous line length before it is overwritten.
    line_bad = hs_fall & (hcnt_inc != h_total_q);
  end

  // Active-pixel tracking: registered de/x/y, x/y hold through blanking.
  always_comb begin
    xcnt_d = xcnt_q;
    de_d   = de_q;
    x_d    = x_q;
    y_d    = y_q;
    if (pix_en) begin
      de_d = vga_blank_n;
      if (vga_blank_n) begin
        x_d = xcnt_q;
        y_d = ycnt_q;
      end
    end
    if (hs_fall) begin
      xcnt_d = '0;
    end else if (pix_en && vga_blank_n && !(&xcnt_q)) begin
      xcnt_d = xcnt_q + H_ONE;
    end
  end

  // Vertical counters and per-frame measurements, closed out on vsync fall.
  always_comb begin
    ycnt_step  = (bl_fall && !(&ycnt_q)) ? ycnt_q + V_ONE : ycnt_q;
    // An hsync fall coincident with vsync fall belongs to the frame being closed.
    vcnt_next  = (hs_fall && !(&vcnt_q)) ? vcnt_q + V_ONE : vcnt_q;
    h_active_d = bl_fall ? xcnt_q : h_active_q;
    v_active_d = v_active_q;
    v_total_d  = v_total_q;
    ycnt_d     = ycnt_step;
    vcnt_d     = vcnt_next;
    if (vs_fall) begin
      v_total_d  = vcnt_next;
      v_active_d = ycnt_step;
      vcnt_d     = '0;
      ycnt_d     = '0;
    end
  end

  // Lock tracking: compare each completed frame's geometry with the previous one.
  always_comb begin
    frame_meas  = {h_total_d, h_active_d, v_active_d, v_total_d};
    // The line ending in the vsync-fall sample still counts against this frame.
    frame_match = snap_vld_q && (frame_meas == snap_q) && !frame_bad_q && !line_bad;
    match_d     = match_q;
    locked_d    = locked_q;
    snap_d      = snap_q;
    snap_vld_d  = snap_vld_q;
    frame_bad_d = frame_bad_q | line_bad;
    if (vs_fall) begin
      frame_bad_d = 1'b0;
      snap_d      = frame_meas;
      snap_vld_d  = 1'b1;
      if (frame_match) begin
        match_d = (match_q >= LOCK_MAX) ? LOCK_MAX : match_q + 4'd1;
      end else begin
        match_d = '0;
      end
      locked_d = (match_d == LOCK_MAX);
    end
    // Loss of hsync overrides any frame result in the same sample.
    if (sync_loss) begin
      match_d  = '0;
      locked_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Previous-sample history for the edge detectors; idle sync levels are high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      bl_q <= 1'b0;
    end else if (pix_en) begin
      hs_q <= hsync;
      vs_q <= vsync;
      bl_q <= vga_blank_n;
    end
  end

  // Position counters and geometry measurements.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q     <= '0;
      xcnt_q     <= '0;
      ycnt_q     <= '0;
      vcnt_q     <= '0;
      h_total_q  <= '0;
      h_active_q <= '0;
      v_active_q <= '0;
      v_total_q  <= '0;
    end else if (pix_en) begin
      hcnt_q     <= hcnt_d;
      xcnt_q     <= xcnt_d;
      ycnt_q     <= ycnt_d;
      vcnt_q     <= vcnt_d;
      h_total_q  <= h_total_d;
      h_active_q <= h_active_d;
      v_active_q <= v_active_d;
      v_total_q  <= v_total_d;
    end
  end

  // Per-pixel outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
    end else if (pix_en) begin
      de_q <= de_d;
      x_q  <= x_d;
      y_q  <= y_d;
    end
  end

  // frame_start is refreshed every clk so it is a single-clk pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fs_q <= 1'b0;
    end else begin
      fs_q <= vs_fall;
    end
  end

  // Lock state, frame-quality flag and previous-frame snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_q     <= '0;
      locked_q    <= 1'b0;
      frame_bad_q <= 1'b0;
      snap_q      <= '0;
      snap_vld_q  <= 1'b0;
    end else if (pix_en) begin
      match_q     <= match_d;
      locked_q    <= locked_d;
      frame_bad_q <= frame_bad_d;
      snap_q      <= snap_d;
      snap_vld_q  <= snap_vld_d;
    end
  end

  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;
  assign h_total     = h_total_q;
  assign h_active    = h_active_q;
  assign v_active    = v_active_q;
  assign v_total     = v_total_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Purpose: directed self-check of vga_timing_monitor using a scaled-down VGA raster.
// Latency: outputs sampled on the negedge following each pix_en cycle.
// Backpressure: none; stimulus is a free-running pix_en every 2nd clk.
module tb_vga_timing_monitor;

  localparam int HW    = 10;
  localparam int VW    = 10;
  localparam int LOCKF = 2;

  // Scaled raster: 40 px/line (32 active), 12 lines/frame (8 active).
  // hsync low on px 34..37; vsync falls together with hsync on line 9 and
  // rises at the start of line 10, where each frame of stimulus begins.
  localparam int H_TOT        = 40;
  localparam int H_ACT        = 32;
  localparam int H_SYNC_START = 34;
  localparam int H_SYNC_LEN   = 4;
  localparam int V_TOT        = 12;
  localparam int V_ACT        = 8;
  localparam int V_SYNC_LINE  = 9;
  localparam int FIRST_LINE   = 10;
  localparam int NVEC         = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_en;
  logic          hsync;
  logic          vsync;
  logic          vga_blank_n;
  logic          de;
  logic [HW-1:0] x;
  logic [VW-1:0] y;
  logic          frame_start;
  logic [HW-1:0] h_total;
  logic [HW-1:0] h_active;
  logic [VW-1:0] v_active;
  logic [VW-1:0] v_total;
  logic          locked;

  int tests = 0;
  int fails = 0;
  int fs_cycles = 0;

  vga_timing_monitor #(
    .LOG2_DISPLAY_WIDTH (HW),
    .LOG2_DISPLAY_HEIGHT(VW),
    .LOCK_FRAMES        (LOCKF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .hsync      (hsync),
    .vsync      (vsync),
    .vga_blank_n(vga_blank_n),
    .de         (de),
    .x          (x),
    .y          (y),
    .frame_start(frame_start),
    .h_total    (h_total),
    .h_active   (h_active),
    .v_active   (v_active),
    .v_total    (v_total),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  // Width of every frame_start pulse, in clocks.
  always @(negedge clk) begin
    if (frame_start) fs_cycles++;
  end

  typedef struct {
    int long_line;  // line stretched to H_TOT+1 pixels, -1 for none
    bit chk_pix;    // check de/x/y at the first/last active pixel
    int exp_htot;
    int exp_hact;
    int exp_vact;
    int exp_vtot;
    int exp_lock;
  } frame_vec_t;

  frame_vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One pix_en sample; returns on the negedge after the sampling posedge.
  task automatic sample(input logic hs, input logic vs, input logic bl);
    @(negedge clk);
    pix_en      = 1'b1;
    hsync       = hs;
    vsync       = vs;
    vga_blank_n = bl;
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  function automatic logic hs_at(input int px);
    return !(px >= H_SYNC_START && px < H_SYNC_START + H_SYNC_LEN);
  endfunction

  function automatic logic vs_at(input int line, input int px);
    return !(line == V_SYNC_LINE && px >= H_SYNC_START);
  endfunction

  function automatic logic bl_at(input int line, input int px);
    return (line < V_ACT) && (px < H_ACT);
  endfunction

  // One full frame from line FIRST_LINE px 0 to line V_SYNC_LINE end.
  task automatic run_frame(input int long_line, input bit chk_pix);
    for (int li = 0; li < V_TOT; li++) begin
      int line;
      int len;
      line = (FIRST_LINE + li) % V_TOT;
      len  = (line == long_line) ? H_TOT + 1 : H_TOT;
      for (int px = 0; px < len; px++) begin
        sample(hs_at(px), vs_at(line, px), bl_at(line, px));
        if (chk_pix && line == 0 && px == 0) begin
          check("first_px_de", de, 1);
          check("first_px_x", x, 0);
          check("first_px_y", y, 0);
        end
        if (chk_pix && line == V_ACT - 1 && px == H_ACT - 1) begin
          check("last_px_de", de, 1);
          check("last_px_x", x, H_ACT - 1);
          check("last_px_y", y, V_ACT - 1);
        end
        if (chk_pix && line == V_ACT - 1 && px == H_ACT) begin
          check("after_last_de", de, 0);
          check("after_last_x_hold", x, H_ACT - 1);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int fs0;

    // Frame-level vectors: clean lock-up, one long line, relock.
    vecs[0] = '{-1, 1'b1, H_TOT, H_ACT, V_ACT, V_TOT, 0};
    vecs[1] = '{-1, 1'b0, H_TOT, H_ACT, V_ACT, V_TOT, 0};
    vecs[2] = '{-1, 1'b0, H_TOT, H_ACT, V_ACT, V_TOT, 1};
    vecs[3] = '{-1, 1'b1, H_TOT, H_ACT, V_ACT, V_TOT, 1};
    vecs[4] = '{ 2, 1'b0, H_TOT, H_ACT, V_ACT, V_TOT, 0};
    vecs[5] = '{-1, 1'b0, H_TOT, H_ACT, V_ACT, V_TOT, 0};
    vecs[6] = '{-1, 1'b0, H_TOT, H_ACT, V_ACT, V_TOT, 1};

    rst         = 1'b1;
    pix_en      = 1'b0;
    hsync       = 1'b1;
    vsync       = 1'b1;
    vga_blank_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {de, x, y, frame_start, h_total, h_active, v_active, v_total, locked}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      fs0 = fs_cycles;
      run_frame(vecs[i].long_line, vecs[i].chk_pix);
      check($sformatf("f%0d_h_total", i), h_total, vecs[i].exp_htot);
      check($sformatf("f%0d_h_active", i), h_active, vecs[i].exp_hact);
      check($sformatf("f%0d_v_active", i), v_active, vecs[i].exp_vact);
      check($sformatf("f%0d_v_total", i), v_total, vecs[i].exp_vtot);
      check($sformatf("f%0d_locked", i), locked, vecs[i].exp_lock);
      check($sformatf("f%0d_frame_start_clks", i), fs_cycles - fs0, 1);
    end

    // Asynchronous reset in the middle of a line while locked.
    for (int px = 0; px < 15; px++) sample(hs_at(px), 1'b1, 1'b0);
    #3 rst = 1'b1;
    #1 check("midline_reset_outputs",
             {de, x, y, frame_start, h_total, h_active, v_active, v_total, locked}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int f = 0; f < 3; f++) begin
      run_frame(-1, 1'b0);
      check($sformatf("relock_f%0d_locked", f), locked, (f == 2) ? 1 : 0);
    end
    check("relock_v_total", v_total, V_TOT);

    // hsync stuck high: hcnt is 5 after the frame tail, reaching all-ones
    // after 1018 more samples; the next sample is the sync loss.
    repeat (1018) sample(1'b1, 1'b1, 1'b0);
    check("pre_sat_locked", locked, 1);
    sample(1'b1, 1'b1, 1'b0);
    check("sat_locked", locked, 0);
    check("sat_h_total_hold", h_total, H_TOT);
    repeat (5) sample(1'b1, 1'b1, 1'b0);
    check("sat_h_total_still", h_total, H_TOT);
    // Next hsync fall measures the saturated count + 1, which wraps to 0 in 10 bits.
    sample(1'b0, 1'b1, 1'b0);
    check("sat_h_total_after_fall", h_total, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
